id_ex_stage: RTL and testbench

ID/EX pipeline boundary of the 16-bit WISC core. Captures the two register-file read operands, immediate, destination register and control bits from decode, and presents them registered to execute. Detects load-use hazards against the instruction currently in EX, inserting one bubble and stalling decode. Also handles downstream hold requests and branch flushes, including a flush that arrives while EX is held.

---
 rtl/wisc_pkg.sv | 45 ++++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared widths, ALU opcodes and the ID/EX bundle type for the WISC core
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_XOR    = 4'h2,
    ALU_RED    = 4'h3,
    ALU_SLL    = 4'h4,
    ALU_SRA    = 4'h5,
    ALU_ROR    = 4'h6,
    ALU_PADDSB = 4'h7,
    ALU_LW     = 4'h8,
    ALU_SW     = 4'h9,
    ALU_LHB    = 4'hA,
    ALU_LLB    = 4'hB,
    ALU_B      = 4'hC,
    ALU_BR     = 4'hD,
    ALU_PCS    = 4'hE,
    ALU_HLT    = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] pc_plus2;
    logic [DATA_W-1:0] src_data1;
    logic [DATA_W-1:0] src_data2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] src_reg1;
    logic [ADDR_W-1:0] src_reg2;
    logic [ADDR_W-1:0] dst_reg;
    logic [OP_W-1:0]   alu_op;
  } id_ex_bundle_t;

  // A bubble is an all-zero slot: not valid, no side effects, no data.
  localparam id_ex_bundle_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX and ID
module load_use_detect
  import wisc_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [ADDR_W-1:0] ex_dst_reg_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_src_reg1_i,
  input  logic [ADDR_W-1:0] id_src_reg2_i,
  input  logic              id_uses_src2_i,
  output logic              hazard_o
);

  logic ex_is_load;
  logic match1;
  logic match2;

  // r0 always reads as zero, so a load targeting it never creates a dependency.
  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_dst_reg_i != '0);
  assign match1     = (ex_dst_reg_i == id_src_reg1_i);
  assign match2     = id_uses_src2_i & (ex_dst_reg_i == id_src_reg2_i);
  assign hazard_o   = ex_is_load & id_valid_i & (match1 | match2);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, EX hold and branch flush
module id_ex_stage
  import wisc_pkg::*;
#(
  parameter logic [15:0] BUBBLE_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus2,
  input  logic [DATA_W-1:0] id_src_data1,
  input  logic [DATA_W-1:0] id_src_data2,
  input  logic [ADDR_W-1:0] id_src_reg1,
  input  logic [ADDR_W-1:0] id_src_reg2,
  input  logic              id_uses_src2,
  input  logic [ADDR_W-1:0] id_dst_reg,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_pc_plus2,
  output logic [DATA_W-1:0] ex_src_data1,
  output logic [DATA_W-1:0] ex_src_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_src_reg1,
  output logic [ADDR_W-1:0] ex_src_reg2,
  output logic [ADDR_W-1:0] ex_dst_reg,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic              stall_id,
  output logic [15:0]       bubble_count
);

  id_ex_bundle_t id_bundle;
  id_ex_bundle_t ex_d;
  id_ex_bundle_t ex_q;
  logic          pend_flush_d;
  logic          pend_flush_q;
  logic [15:0]   bubble_cnt_d;
  logic [15:0]   bubble_cnt_q;
  logic          hazard;

  load_use_detect u_load_use_detect (
    .ex_valid_i     (ex_q.valid),
    .ex_mem_read_i  (ex_q.mem_read),
    .ex_dst_reg_i   (ex_q.dst_reg),
    .id_valid_i     (id_valid),
    .id_src_reg1_i  (id_src_reg1),
    .id_src_reg2_i  (id_src_reg2),
    .id_uses_src2_i (id_uses_src2),
    .hazard_o       (hazard)
  );

  // A held EX already freezes decode, so the hazard term only matters when EX moves.
  assign stall_id = ex_stall | (hazard & ~ex_stall);

  // Gather decode fields; an invalid slot carries no side-effecting controls.
  always_comb begin
    id_bundle           = BUBBLE;
    id_bundle.valid     = id_valid;
    id_bundle.reg_write = id_reg_write & id_valid;
    id_bundle.mem_read  = id_mem_read & id_valid;
    id_bundle.mem_write = id_mem_write & id_valid;
    id_bundle.pc_plus2  = id_pc_plus2;
    id_bundle.src_data1 = id_src_data1;
    id_bundle.src_data2 = id_src_data2;
    id_bundle.imm       = id_imm;
    id_bundle.src_reg1  = id_src_reg1;
    id_bundle.src_reg2  = id_src_reg2;
    id_bundle.dst_reg   = id_dst_reg;
    id_bundle.alu_op    = id_alu_op;
  end

  // Next state: hold, then flush (possibly remembered from a hold), then hazard, then load.
  always_comb begin
    ex_d         = ex_q;
    pend_flush_d = pend_flush_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ex_stall) begin
      pend_flush_d = pend_flush_q | flush;
    end else if (flush | pend_flush_q) begin
      ex_d         = BUBBLE;
      pend_flush_d = 1'b0;
    end else if (hazard) begin
      ex_d = BUBBLE;
      if (bubble_cnt_q != BUBBLE_MAX) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end else begin
      ex_d = id_bundle;
    end
  end

  // Pipeline register, pending-flush flag and bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q         <= BUBBLE;
      pend_flush_q <= 1'b0;
      bubble_cnt_q <= 16'd0;
    end else begin
      ex_q         <= ex_d;
      pend_flush_q <= pend_flush_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_pc_plus2  = ex_q.pc_plus2;
  assign ex_src_data1 = ex_q.src_data1;
  assign ex_src_data2 = ex_q.src_data2;
  assign ex_imm       = ex_q.imm;
  assign ex_src_reg1  = ex_q.src_reg1;
  assign ex_src_reg2  = ex_q.src_reg2;
  assign ex_dst_reg   = ex_q.dst_reg;
  assign ex_alu_op    = ex_q.alu_op;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import wisc_pkg::*;

  localparam logic [15:0] SAT = 16'h0005;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc_plus2, id_src_data1, id_src_data2, id_imm;
  logic [ADDR_W-1:0] id_src_reg1, id_src_reg2, id_dst_reg;
  logic              id_uses_src2;
  logic [OP_W-1:0]   id_alu_op;
  logic              id_reg_write, id_mem_read, id_mem_write;
  logic              flush, ex_stall;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [DATA_W-1:0] ex_pc_plus2, ex_src_data1, ex_src_data2, ex_imm;
  logic [ADDR_W-1:0] ex_src_reg1, ex_src_reg2, ex_dst_reg;
  logic [OP_W-1:0]   ex_alu_op;
  logic              stall_id;
  logic [15:0]       bubble_count;

  id_ex_stage #(.BUBBLE_MAX(SAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc_plus2(id_pc_plus2),
    .id_src_data1(id_src_data1), .id_src_data2(id_src_data2),
    .id_src_reg1(id_src_reg1), .id_src_reg2(id_src_reg2), .id_uses_src2(id_uses_src2),
    .id_dst_reg(id_dst_reg), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc_plus2(ex_pc_plus2),
    .ex_src_data1(ex_src_data1), .ex_src_data2(ex_src_data2), .ex_imm(ex_imm),
    .ex_src_reg1(ex_src_reg1), .ex_src_reg2(ex_src_reg2), .ex_dst_reg(ex_dst_reg),
    .ex_alu_op(ex_alu_op), .stall_id(stall_id), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: what EX should hold, whether a flush is owed, bubbles counted.
  id_ex_bundle_t m_ex;
  logic          m_pend;
  logic [15:0]   m_cnt;

  typedef struct {
    logic        v;
    logic [3:0]  r1, r2, dst;
    logic        u2, rw, mr;
    logic [15:0] d1;
    logic        fl;
    logic        e_stall, e_valid, e_rw;
    logic [15:0] e_d1;
    logic [3:0]  e_dst;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic id_ex_bundle_t dut_bundle();
    id_ex_bundle_t b;
    b.valid = ex_valid;         b.reg_write = ex_reg_write;
    b.mem_read = ex_mem_read;   b.mem_write = ex_mem_write;
    b.pc_plus2 = ex_pc_plus2;   b.src_data1 = ex_src_data1;
    b.src_data2 = ex_src_data2; b.imm = ex_imm;
    b.src_reg1 = ex_src_reg1;   b.src_reg2 = ex_src_reg2;
    b.dst_reg = ex_dst_reg;     b.alu_op = ex_alu_op;
    return b;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bundle(input string name);
    id_ex_bundle_t a;
    a = dut_bundle();
    checks++;
    if (a !== m_ex) begin
      failures++;
      $display("FAIL %s ex_bundle actual=%h expected=%h t=%0t", name, a, m_ex, $time);
    end
  endtask

  // Decode depends on a load in EX whose nonzero target it actually reads.
  function automatic logic model_hazard();
    logic reads1, reads2;
    reads1 = (m_ex.dst_reg == id_src_reg1);
    reads2 = id_uses_src2 && (m_ex.dst_reg == id_src_reg2);
    return id_valid && m_ex.valid && m_ex.mem_read && (m_ex.dst_reg != 4'd0) && (reads1 || reads2);
  endfunction

  task automatic model_reset();
    m_ex = '0; m_pend = 1'b0; m_cnt = 16'd0;
  endtask

  task automatic model_edge();
    if (ex_stall) begin
      m_pend = m_pend || flush;
    end else if (flush || m_pend) begin
      m_ex = '0; m_pend = 1'b0;
    end else if (model_hazard()) begin
      m_ex = '0;
      if (m_cnt < SAT) m_cnt = m_cnt + 16'd1;
    end else begin
      m_ex.valid = id_valid;
      m_ex.reg_write = id_valid && id_reg_write;
      m_ex.mem_read = id_valid && id_mem_read;
      m_ex.mem_write = id_valid && id_mem_write;
      m_ex.pc_plus2 = id_pc_plus2;   m_ex.src_data1 = id_src_data1;
      m_ex.src_data2 = id_src_data2; m_ex.imm = id_imm;
      m_ex.src_reg1 = id_src_reg1;   m_ex.src_reg2 = id_src_reg2;
      m_ex.dst_reg = id_dst_reg;     m_ex.alu_op = id_alu_op;
    end
  endtask

  task automatic drive_id(input logic v, input logic [15:0] pc, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [3:0] r1, input logic [3:0] r2,
                          input logic u2, input logic [3:0] dst, input logic [15:0] imm,
                          input logic [3:0] op, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_pc_plus2 = pc; id_src_data1 = d1; id_src_data2 = d2;
    id_src_reg1 = r1; id_src_reg2 = r2; id_uses_src2 = u2; id_dst_reg = dst;
    id_imm = imm; id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  // One clock: check stall_id before the edge, advance model and DUT, check after.
  task automatic cycle(input string tag);
    #1;
    check16({tag, ":stall_id"}, {15'd0, stall_id}, {15'd0, ex_stall || model_hazard()});
    model_edge();
    @(posedge clk);
    #1;
    check_bundle(tag);
    check16({tag, ":bubble_count"}, bubble_count, m_cnt);
  endtask

  // Assert reset a few ns after an edge and check outputs before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_bundle({tag, ":async"});
    check16({tag, ":async_cnt"}, bubble_count, 16'd0);
    check16({tag, ":async_stall"}, {15'd0, stall_id}, 16'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1);
  end

  initial begin
    //          v    r1    r2    dst   u2   rw   mr   d1         fl   stl  val  rw   e_d1       e_dst e_cnt
    vecs[0]  = '{1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 4'd3, 16'd0};
    vecs[1]  = '{1'b1, 4'd2, 4'd0, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 4'd4, 16'd0};
    vecs[2]  = '{1'b1, 4'd4, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd1};
    vecs[3]  = '{1'b1, 4'd4, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 16'hAAAA, 4'd5, 16'd1};
    vecs[4]  = '{1'b1, 4'd1, 4'd1, 4'd0, 1'b1, 1'b1, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 4'd0, 16'd1};
    vecs[5]  = '{1'b1, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 1'b1, 16'h0066, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0066, 4'd6, 16'd1};
    vecs[6]  = '{1'b1, 4'd1, 4'd6, 4'd7, 1'b0, 1'b1, 1'b0, 16'h0077, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0077, 4'd7, 16'd1};
    vecs[7]  = '{1'b0, 4'd7, 4'd7, 4'd2, 1'b1, 1'b1, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 4'd2, 16'd1};
    vecs[8]  = '{1'b1, 4'd1, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 16'h0BBB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd1};
    vecs[9]  = '{1'b1, 4'd3, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1, 16'h0029, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0029, 4'd2, 16'd1};
    vecs[10] = '{1'b1, 4'd2, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0ABC, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd1};
    vecs[11] = '{1'b1, 4'd2, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0ABC, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0ABC, 4'd3, 16'd1};

    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    drive_id(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_bundle("reset");
    check16("reset:bubble_count", bubble_count, 16'd0);
    check16("reset:stall_id", {15'd0, stall_id}, 16'd0);
    rst = 1'b0;

    // Directed table: straight load, load-use, r0, unused src2, invalid slot, flush, flush+hazard.
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive_id(vecs[i].v, 16'h0100 + 16'(2 * i), vecs[i].d1, 16'(3 * i), vecs[i].r1, vecs[i].r2,
               vecs[i].u2, vecs[i].dst, ~16'(i), ALU_ADD, vecs[i].rw, vecs[i].mr, 1'b0);
      flush = vecs[i].fl;
      #1;
      check16({tag, ":tbl_stall"}, {15'd0, stall_id}, {15'd0, vecs[i].e_stall});
      cycle(tag);
      check16({tag, ":tbl_valid"}, {15'd0, ex_valid}, {15'd0, vecs[i].e_valid});
      check16({tag, ":tbl_reg_write"}, {15'd0, ex_reg_write}, {15'd0, vecs[i].e_rw});
      check16({tag, ":tbl_data1"}, ex_src_data1, vecs[i].e_d1);
      check16({tag, ":tbl_dst"}, {12'd0, ex_dst_reg}, {12'd0, vecs[i].e_dst});
      check16({tag, ":tbl_cnt"}, bubble_count, vecs[i].e_cnt);
    end
    flush = 1'b0;

    // Flush arriving during a 3-cycle hold: EX frozen, then one bubble, then a normal load.
    drive_id(1'b1, 16'h0200, 16'h1234, 16'h0001, 4'd1, 4'd2, 1'b1, 4'd9, 16'h0, ALU_SUB, 1'b1, 1'b0, 1'b0);
    cycle("hold_load");
    check16("hold_load:data1", ex_src_data1, 16'h1234);
    for (int c = 0; c < 3; c++) begin
      drive_id(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
               1'b1, 4'($urandom), 16'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b0);
      ex_stall = 1'b1;
      flush = (c == 0);
      cycle($sformatf("hold%0d", c));
      check16($sformatf("hold%0d:valid", c), {15'd0, ex_valid}, 16'd1);
      check16($sformatf("hold%0d:data1", c), ex_src_data1, 16'h1234);
      check16($sformatf("hold%0d:dst", c), {12'd0, ex_dst_reg}, 16'd9);
    end
    ex_stall = 1'b0; flush = 1'b0;
    drive_id(1'b1, 16'h0202, 16'h5678, 16'h0002, 4'd1, 4'd2, 1'b1, 4'd10, 16'h0, ALU_ADD, 1'b1, 1'b0, 1'b0);
    cycle("hold_bubble");
    check16("hold_bubble:valid", {15'd0, ex_valid}, 16'd0);
    check16("hold_bubble:cnt", bubble_count, 16'd1);
    cycle("hold_after");
    check16("hold_after:valid", {15'd0, ex_valid}, 16'd1);
    check16("hold_after:data1", ex_src_data1, 16'h5678);

    // Reset during a hold with a flush owed: the first edge after reset loads normally.
    ex_stall = 1'b1; flush = 1'b1;
    cycle("rst_stall");
    ex_stall = 1'b0; flush = 1'b0;
    async_reset("rst_mid");
    drive_id(1'b1, 16'h0300, 16'h0B0B, 16'h0003, 4'd1, 4'd2, 1'b1, 4'd11, 16'h0, ALU_XOR, 1'b1, 1'b0, 1'b0);
    cycle("post_rst");
    check16("post_rst:valid", {15'd0, ex_valid}, 16'd1);
    check16("post_rst:dst", {12'd0, ex_dst_reg}, 16'd11);

    // Saturation of the bubble counter at its ceiling.
    for (int k = 1; k <= 7; k++) begin
      drive_id(1'b1, 16'h0400, 16'h0000, 16'h0000, 4'd1, 4'd0, 1'b0, 4'd4, 16'h0004, ALU_LW, 1'b1, 1'b1, 1'b0);
      cycle($sformatf("sat_lw%0d", k));
      drive_id(1'b1, 16'h0402, 16'h0000, 16'h0000, 4'd4, 4'd1, 1'b1, 4'd5, 16'h0000, ALU_ADD, 1'b1, 1'b0, 1'b0);
      cycle($sformatf("sat_use%0d", k));
      check16($sformatf("sat%0d:cnt", k), bubble_count, (k < 5) ? 16'(k) : SAT);
    end

    // Random traffic over a small register space so hazards are frequent.
    for (int n = 0; n < 1500; n++) begin
      drive_id($urandom_range(0, 99) < 85, 16'($urandom), 16'($urandom), 16'($urandom),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
               4'($urandom_range(0, 3)), 16'($urandom), 4'($urandom), 1'($urandom),
               $urandom_range(0, 1) == 1, 1'($urandom));
      ex_stall = $urandom_range(0, 99) < 20;
      flush = $urandom_range(0, 99) < 10;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
